// File: rtl/dmem_arbiter_if.sv
// Bundled load/store request, load response and shared DMEM port signals.
// slave: the arbiter's view. master: the CPU/memory environment's view.
interface dmem_arbiter_if #(
  parameter int unsigned TAG_BITS      = 4,
  parameter int unsigned CPU_ADDR_BITS = 32,
  parameter int unsigned CPU_DATA_BITS = 32
);
  logic                     ld_req_val;
  logic                     ld_req_rdy;
  logic [CPU_ADDR_BITS-1:0] ld_req_addr;
  logic [TAG_BITS-1:0]      ld_req_tag;
  logic                     ld_resp_val;
  logic [CPU_DATA_BITS-1:0] ld_resp_data;
  logic [TAG_BITS-1:0]      ld_resp_tag;
  logic                     st_req_val;
  logic                     st_req_rdy;
  logic [CPU_ADDR_BITS-1:0] st_req_addr;
  logic [CPU_DATA_BITS-1:0] st_req_data;
  logic [3:0]               st_req_be;
  logic                     st_drain;
  logic                     flush;
  logic [CPU_ADDR_BITS-1:0] dcache_addr;
  logic                     dcache_re;
  logic [CPU_DATA_BITS-1:0] dcache_din;
  logic [3:0]               dcache_we;
  logic [CPU_DATA_BITS-1:0] dcache_dout;
  logic                     dcache_dout_val;
  logic                     dcache_stall;

  modport slave (
    input  ld_req_val, ld_req_addr, ld_req_tag,
    input  st_req_val, st_req_addr, st_req_data, st_req_be, st_drain, flush,
    input  dcache_dout, dcache_dout_val,
    output ld_req_rdy, ld_resp_val, ld_resp_data, ld_resp_tag, st_req_rdy,
    output dcache_addr, dcache_re, dcache_din, dcache_we, dcache_stall
  );

  modport master (
    output ld_req_val, ld_req_addr, ld_req_tag,
    output st_req_val, st_req_addr, st_req_data, st_req_be, st_drain, flush,
    output dcache_dout, dcache_dout_val,
    input  ld_req_rdy, ld_resp_val, ld_resp_data, ld_resp_tag, st_req_rdy,
    input  dcache_addr, dcache_re, dcache_din, dcache_we, dcache_stall
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Load/store arbiter for a single shared DMEM port with 1-cycle load responses.
// Define DMEM_ARB_STARVE_EN to add the store starvation counter and forced store grant.
module dmem_arbiter #(
  parameter int unsigned TAG_BITS      = 4,
  parameter int unsigned STARVE_LIMIT  = 4,
  parameter int unsigned CPU_ADDR_BITS = 32,
  parameter int unsigned CPU_DATA_BITS = 32
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  logic                ld_gnt;
  logic                st_gnt;
  logic                ld_can;
  logic                st_can;
  logic                st_pri;
  logic                starve_hit;
  logic                inflight_val;
  logic [TAG_BITS-1:0] inflight_tag;

`ifdef DMEM_ARB_STARVE_EN
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] starve_cnt;
  logic [CntW-1:0] starve_cnt_next;

  assign starve_hit = (starve_cnt == CntMax);

  always_comb begin
    starve_cnt_next = starve_cnt;
    if (!bus.st_req_val || st_gnt) begin
      starve_cnt_next = '0;
    end else if (starve_cnt != CntMax) begin
      starve_cnt_next = starve_cnt + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_next;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  // Reset gates grants combinationally so the DMEM port is idle while rst is high.
  assign ld_can = bus.ld_req_val && !bus.flush && !rst;
  assign st_can = bus.st_req_val && !rst;
  assign st_pri = bus.st_drain || starve_hit;

  always_comb begin
    ld_gnt = 1'b0;
    st_gnt = 1'b0;
    if (st_pri) begin
      st_gnt = st_can;
      ld_gnt = ld_can && !st_can;
    end else begin
      ld_gnt = ld_can;
      st_gnt = st_can && !ld_can;
    end
  end

  always_comb begin
    bus.dcache_addr = '0;
    bus.dcache_din  = '0;
    bus.dcache_re   = 1'b0;
    bus.dcache_we   = 4'b0000;
    if (ld_gnt) begin
      bus.dcache_addr = bus.ld_req_addr;
      bus.dcache_re   = 1'b1;
    end else if (st_gnt) begin
      bus.dcache_addr = bus.st_req_addr;
      bus.dcache_din  = bus.st_req_data;
      bus.dcache_we   = bus.st_req_be;
    end
  end

  // A flush cycle never grants a load, so the in-flight bit clears at that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_val <= 1'b0;
      inflight_tag <= '0;
    end else begin
      inflight_val <= ld_gnt;
      if (ld_gnt) begin
        inflight_tag <= bus.ld_req_tag;
      end
    end
  end

  assign bus.ld_req_rdy   = ld_gnt;
  assign bus.st_req_rdy   = st_gnt;
  assign bus.ld_resp_val  = inflight_val && bus.dcache_dout_val && !bus.flush && !rst;
  assign bus.ld_resp_data = bus.dcache_dout;
  assign bus.ld_resp_tag  = inflight_tag;
  assign bus.dcache_stall = 1'b0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// compared against a behavioural grant/memory reference model.
module tb_dmem_arbiter;
  localparam int unsigned TagBits     = 4;
  localparam int unsigned StarveLimit = 4;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit StarveEn = 1'b1;
`else
  localparam bit StarveEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.TAG_BITS(TagBits), .CPU_ADDR_BITS(32), .CPU_DATA_BITS(32)) bus ();

  dmem_arbiter #(
    .TAG_BITS      (TagBits),
    .STARVE_LIMIT  (StarveLimit),
    .CPU_ADDR_BITS (32),
    .CPU_DATA_BITS (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Environment memory behind the DMEM port: read data valid one cycle after re.
  logic [31:0] dmem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 32'(i) * 32'h9E3779B9;
      bus.dcache_dout_val <= 1'b0;
      bus.dcache_dout     <= '0;
    end else begin
      bus.dcache_dout_val <= bus.dcache_re;
      if (bus.dcache_re) bus.dcache_dout <= dmem[bus.dcache_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (bus.dcache_we[b]) dmem[bus.dcache_addr[9:2]][8*b +: 8] <= bus.dcache_din[8*b +: 8];
    end
  end

  // Reference model state
  logic [31:0]        ref_mem [256];
  bit                 m_inflight;
  logic [TagBits-1:0] m_tag;
  logic [31:0]        m_data;
  int unsigned        m_starve;

  int checks = 0;
  int errors = 0;
  int st_rdy_seen = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_inflight = 1'b0;
    m_starve   = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i) * 32'h9E3779B9;
  endtask

  // One clock cycle: inputs already driven; check at negedge, advance model at posedge.
  task automatic step();
    bit          pri, ld_can, st_can, eg_ld, eg_st, e_resp;
    logic [31:0] e_addr, e_din;
    logic [3:0]  e_we;
    @(negedge clk);
    pri    = bus.st_drain || (StarveEn && m_starve >= StarveLimit);
    ld_can = bus.ld_req_val && !bus.flush && !rst;
    st_can = bus.st_req_val && !rst;
    eg_ld  = pri ? (ld_can && !st_can) : ld_can;
    eg_st  = pri ? st_can : (st_can && !ld_can);
    e_addr = eg_ld ? bus.ld_req_addr : (eg_st ? bus.st_req_addr : 32'h0);
    e_din  = eg_st ? bus.st_req_data : 32'h0;
    e_we   = eg_st ? bus.st_req_be : 4'h0;
    e_resp = m_inflight && !bus.flush && !rst;
    chk("ld_req_rdy", 64'(bus.ld_req_rdy), 64'(eg_ld));
    chk("st_req_rdy", 64'(bus.st_req_rdy), 64'(eg_st));
    chk("dcache_re", 64'(bus.dcache_re), 64'(eg_ld));
    chk("dcache_we", 64'(bus.dcache_we), 64'(e_we));
    chk("dcache_addr", 64'(bus.dcache_addr), 64'(e_addr));
    chk("dcache_din", 64'(bus.dcache_din), 64'(e_din));
    chk("dcache_stall", 64'(bus.dcache_stall), 64'h0);
    chk("ld_resp_val", 64'(bus.ld_resp_val), 64'(e_resp));
    if (e_resp) begin
      chk("ld_resp_data", 64'(bus.ld_resp_data), 64'(m_data));
      chk("ld_resp_tag", 64'(bus.ld_resp_tag), 64'(m_tag));
    end
    if (bus.st_req_rdy === 1'b1) st_rdy_seen++;
    @(posedge clk);
    m_inflight = eg_ld;
    if (eg_ld) begin
      m_tag  = bus.ld_req_tag;
      m_data = ref_mem[bus.ld_req_addr[9:2]];
    end
    if (eg_st)
      for (int b = 0; b < 4; b++)
        if (bus.st_req_be[b]) ref_mem[bus.st_req_addr[9:2]][8*b +: 8] = bus.st_req_data[8*b +: 8];
    if (rst || !bus.st_req_val || eg_st) m_starve = 0;
    else if (m_starve < StarveLimit) m_starve++;
    #1;
  endtask

  task automatic idle();
    bus.ld_req_val = 1'b0;
    bus.st_req_val = 1'b0;
    bus.st_drain   = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic set_ld(input logic [31:0] addr, input logic [TagBits-1:0] tag);
    bus.ld_req_val  = 1'b1;
    bus.ld_req_addr = addr;
    bus.ld_req_tag  = tag;
  endtask

  task automatic set_st(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    bus.st_req_val  = 1'b1;
    bus.st_req_addr = addr;
    bus.st_req_data = data;
    bus.st_req_be   = be;
  endtask

  initial begin
    idle();
    bus.ld_req_addr = '0; bus.ld_req_tag = '0;
    bus.st_req_addr = '0; bus.st_req_data = '0; bus.st_req_be = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Requests held during reset must not be granted.
    set_ld(32'h10, 4'd1);
    set_st(32'h20, 32'h1, 4'hF);
    step();
    idle();
    rst = 1'b0;
    step();

    // Store then load the same address on the next cycle.
    set_st(32'h40, 32'hDEADBEEF, 4'hF);
    step();
    idle();
    set_ld(32'h40, 4'd3);
    step();
    idle();
    @(negedge clk);
    chk("raw_val", 64'(bus.ld_resp_val), 64'h1);
    chk("raw_data", 64'(bus.ld_resp_data), 64'hDEADBEEF);
    chk("raw_tag", 64'(bus.ld_resp_tag), 64'h3);
    @(posedge clk); #1;
    m_inflight = 1'b0;

    // Back-to-back loads, tags 1..3.
    for (int t = 1; t <= 3; t++) begin
      set_ld(32'(t * 8), 4'(t));
      step();
    end
    idle();
    repeat (2) step();

    // Both requesters held high: loads win unless starvation forces a store.
    st_rdy_seen = 0;
    set_ld(32'h80, 4'd5);
    set_st(32'h84, 32'hCAFEF00D, 4'h5);
    repeat (10) step();
    chk("starve_stores", 64'(st_rdy_seen), StarveEn ? 64'd2 : 64'd0);
    idle();
    step();

    // Flush the cycle after a load grant; a store in the flush cycle still writes.
    set_ld(32'h84, 4'd6);
    step();
    idle();
    bus.flush = 1'b1;
    set_ld(32'h88, 4'd7);
    set_st(32'h88, 32'h12345678, 4'hF);
    step();
    idle();
    set_ld(32'h88, 4'd8);
    step();
    idle();
    repeat (2) step();

    // Drain: stores take priority every cycle while valid.
    bus.st_drain = 1'b1;
    set_ld(32'h90, 4'd9);
    for (int i = 0; i < 3; i++) begin
      set_st(32'(32'hA0 + 4 * i), 32'(i + 32'h55), 4'hF);
      step();
    end
    bus.st_req_val = 1'b0;
    step();
    idle();
    step();

    // Reset asserted right after a load grant: outputs drop without a clock edge.
    set_ld(32'h40, 4'd2);
    step();
    set_st(32'h44, 32'h9, 4'hF);
    rst = 1'b1;
    #1;
    chk("arst_resp_val", 64'(bus.ld_resp_val), 64'h0);
    chk("arst_ld_rdy", 64'(bus.ld_req_rdy), 64'h0);
    chk("arst_st_rdy", 64'(bus.st_req_rdy), 64'h0);
    chk("arst_re", 64'(bus.dcache_re), 64'h0);
    chk("arst_we", 64'(bus.dcache_we), 64'h0);
    chk("arst_addr", 64'(bus.dcache_addr), 64'h0);
    model_reset();
    step();
    idle();
    rst = 1'b0;
    step();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      bus.ld_req_val  = ($urandom_range(0, 3) != 0);
      bus.ld_req_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      bus.ld_req_tag  = 4'($urandom);
      bus.st_req_val  = $urandom_range(0, 1) == 1;
      bus.st_req_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      bus.st_req_data = $urandom;
      bus.st_req_be   = 4'($urandom);
      bus.st_drain    = ($urandom_range(0, 7) == 0);
      bus.flush       = ($urandom_range(0, 7) == 0);
      step();
    end
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
